// File: rtl/stage_if_fetch_pkg.sv
// stage_if_fetch_pkg: shared FSM encoding and constants for the instruction fetch stage
package stage_if_fetch_pkg;
  typedef enum logic [3:0] {
    s_INIT = 4'b0001,
    s_IF   = 4'b0010,
    s_IW   = 4'b0100,
    s_HOLD = 4'b1000
  } state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] NOP = 32'h00000013;
endpackage

// File: rtl/stage_if_fetch.sv
// stage_if_fetch: PC owner issuing one imem request at a time and handing {Inst, PC} to ID
module stage_if_fetch
  import stage_if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_I,
  input  logic        rst,
  input  logic [31:0] next_PC,
  input  logic        Feedback_Branch,
  input  logic        Feedback_Mem_Acc,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic [31:0] Inst,
  output logic [31:0] PC_O,
  output logic        Done_O
);
  state_t      state;
  logic        squash;
  logic [31:0] target;
  assign target         = next_PC & ~32'd3;
  assign Inst_Req_Valid = (state == s_IF) && !Feedback_Branch;
  assign Inst_Ready     = (state == s_IW);
  always_ff @(posedge clk_I) begin
    if (rst) begin
      state  <= s_INIT;
      PC     <= RESET_PC;
      Inst   <= 32'h0;
      PC_O   <= 32'h0;
      Done_O <= 1'b0;
      squash <= 1'b0;
    end else begin
      Done_O <= 1'b0;
      unique case (state)
        s_INIT: state <= s_IF;
        s_IF: begin
          if (Feedback_Branch) PC <= target;
          else if (Inst_Req_Ready) state <= s_IW;
        end
        s_IW: begin
          // a redirect in flight marks the outstanding response as stale
          if (Feedback_Branch) begin
            PC     <= target;
            squash <= !Inst_Valid;
            if (Inst_Valid) state <= s_IF;
          end else if (Inst_Valid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= s_IF;
            end else begin
              Inst   <= Instruction;
              PC_O   <= PC;
              PC     <= PC + 32'd4;
              Done_O <= !Feedback_Mem_Acc;
              state  <= Feedback_Mem_Acc ? s_HOLD : s_IF;
            end
          end
        end
        s_HOLD: begin
          if (Feedback_Branch) begin
            PC    <= target;
            state <= s_IF;
          end else if (!Feedback_Mem_Acc) begin
            Done_O <= 1'b1;
            state  <= s_IF;
          end
        end
        default: state <= s_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_if_fetch.sv
// tb_stage_if_fetch: directed scenarios plus random traffic checked against a transaction-level model
module tb_stage_if_fetch;
  import stage_if_fetch_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_PC = '0;
  logic        Feedback_Branch = 1'b0;
  logic        Feedback_Mem_Acc = 1'b0;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready = 1'b0;
  logic [31:0] Instruction = '0;
  logic        Inst_Valid = 1'b0;
  logic        Inst_Ready;
  logic [31:0] Inst;
  logic [31:0] PC_O;
  logic        Done_O;
  int checks = 0;
  int errors = 0;
  // model: where the stage is in its transaction, not how it is encoded
  bit          m_known, m_init, m_out, m_sq, m_held, m_done;
  logic [31:0] m_pc, m_inst, m_pco;
  int          dly;
  logic [31:0] rdata;
  bit          fma_r;
  stage_if_fetch dut (
    .clk_I(clk), .rst(rst), .next_PC(next_PC), .Feedback_Branch(Feedback_Branch),
    .Feedback_Mem_Acc(Feedback_Mem_Acc), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ready(Inst_Req_Ready), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready), .Inst(Inst), .PC_O(PC_O), .Done_O(Done_O)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic step(input bit r, input bit fb, input logic [31:0] tgt, input bit fma,
                      input bit rdy, input int nd, input logic [31:0] ndata);
    bit acc, iv;
    @(negedge clk);
    rst = r; Feedback_Branch = fb; next_PC = tgt; Feedback_Mem_Acc = fma; Inst_Req_Ready = rdy;
    iv = m_out && dly == 0;
    Inst_Valid = iv;
    Instruction = iv ? rdata : $urandom();
    #1;
    if (m_known) begin
      chk("pc", PC, m_pc);
      chk("req_valid", {31'b0, Inst_Req_Valid}, {31'b0, !m_init && !m_out && !m_held && !fb});
      chk("inst_ready", {31'b0, Inst_Ready}, {31'b0, m_out});
      chk("inst", Inst, m_inst);
      chk("pc_o", PC_O, m_pco);
      chk("done", {31'b0, Done_O}, {31'b0, m_done});
    end
    @(posedge clk);
    acc = !r && !m_init && !m_out && !m_held && !fb && rdy;
    if (r) begin
      m_known = 1; m_init = 1; m_out = 0; m_sq = 0; m_held = 0; m_done = 0;
      m_pc = RESET_PC_DEFAULT; m_inst = 0; m_pco = 0;
    end else begin
      m_done = 0;
      if (m_init) m_init = 0;
      else if (m_held) begin
        if (fb) begin m_held = 0; m_pc = tgt & ~32'd3; end
        else if (!fma) begin m_held = 0; m_done = 1; end
      end else if (m_out) begin
        if (fb) begin
          m_pc = tgt & ~32'd3;
          m_sq = !iv;
          if (iv) m_out = 0;
        end else if (iv) begin
          m_out = 0;
          if (m_sq) m_sq = 0;
          else begin
            m_inst = rdata; m_pco = m_pc; m_pc = m_pc + 4;
            if (fma) m_held = 1; else m_done = 1;
          end
        end
      end else if (fb) m_pc = tgt & ~32'd3;
      else if (rdy) m_out = 1;
    end
    if (acc) begin dly = nd; rdata = ndata; end
    else if (m_out && dly > 0) dly--;
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_done", {31'b0, Done_O}, 32'h0);
    chk("rst_req_valid", {31'b0, Inst_Req_Valid}, 32'h0);
    chk("rst_inst", Inst, 32'h0);
    step(0, 0, 0, 0, 1, 0, NOP);
    step(0, 0, 0, 0, 1, 0, NOP);
    step(0, 0, 0, 0, 1, 0, NOP);
    #2;
    chk("t1_done", {31'b0, Done_O}, 32'h1);
    chk("t1_inst", Inst, 32'h00000013);
    chk("t1_pc_o", PC_O, 32'h0);
    chk("t1_pc", PC, 32'h4);
    repeat (4) begin
      step(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("t2_req_valid", {31'b0, Inst_Req_Valid}, 32'h1);
      chk("t2_pc", PC, 32'h4);
      chk("t2_done", {31'b0, Done_O}, 32'h0);
    end
    step(0, 0, 0, 0, 1, 1, 32'hDEAD0000);
    step(0, 1, 32'h100, 0, 0, 0, 0);
    #2;
    chk("t3_done_a", {31'b0, Done_O}, 32'h0);
    chk("t3_pc_a", PC, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t3_done_b", {31'b0, Done_O}, 32'h0);
    chk("t3_pc_b", PC, 32'h100);
    chk("t3_req_valid", {31'b0, Inst_Req_Valid}, 32'h1);
    chk("t3_inst", Inst, 32'h00000013);
    step(0, 0, 0, 0, 1, 0, 32'hA5A50001);
    step(0, 0, 0, 1, 0, 0, 0);
    repeat (4) begin
      step(0, 0, 0, 1, 0, 0, 0);
      #2;
      chk("t4_done_stall", {31'b0, Done_O}, 32'h0);
      chk("t4_inst_stall", Inst, 32'hA5A50001);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t4_done", {31'b0, Done_O}, 32'h1);
    chk("t4_inst", Inst, 32'hA5A50001);
    chk("t4_pc_o", PC_O, 32'h100);
    chk("t4_pc", PC, 32'h104);
    step(0, 0, 0, 0, 1, 0, 32'hBEEF0002);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 32'h203, 1, 0, 0, 0);
    #2;
    chk("t5_done_a", {31'b0, Done_O}, 32'h0);
    chk("t5_pc", PC, 32'h200);
    step(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t5_done_b", {31'b0, Done_O}, 32'h0);
    chk("t5_req_valid", {31'b0, Inst_Req_Valid}, 32'h1);
    step(0, 0, 0, 0, 1, 2, 32'h12345678);
    step(1, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t6_pc", PC, 32'h0);
    chk("t6_done", {31'b0, Done_O}, 32'h0);
    chk("t6_inst", Inst, 32'h0);
    chk("t6_inst_ready", {31'b0, Inst_Ready}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t6_req_valid", {31'b0, Inst_Req_Valid}, 32'h1);
    chk("t6_req_pc", PC, 32'h0);
    fma_r = 0;
    repeat (3000) begin
      if ($urandom_range(0, 4) == 0) fma_r = !fma_r;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom(), fma_r,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)), $urandom());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
